// File: rtl/lif_spike_generator_pkg.sv
// Shared definitions for the LIF spike generator: the control state encoding.
// The optional refractory behaviour is selected with the NEURON_REFRACTORY_EN macro.
package lif_spike_generator_pkg;

  typedef enum logic [1:0] {
    ST_INTEG = 2'd0,
    ST_LEAK  = 2'd1,
    ST_CMP   = 2'd2,
    ST_FIRE  = 2'd3
  } state_e;

endpackage

// File: rtl/sat_add_sub.sv
// Combinational saturating signed add/subtract (y = a + b or a - b).
// Works one bit wider than the operands and clamps to the signed range instead of wrapping.
module sat_add_sub #(
  parameter int DSIZE = 16
) (
  input  logic [DSIZE-1:0] a,
  input  logic [DSIZE-1:0] b,
  input  logic             sub,
  output logic [DSIZE-1:0] y
);

  localparam logic [DSIZE-1:0] SAT_MAX = {1'b0, {(DSIZE-1){1'b1}}};
  localparam logic [DSIZE-1:0] SAT_MIN = {1'b1, {(DSIZE-1){1'b0}}};

  logic [DSIZE:0] a_ext;
  logic [DSIZE:0] b_ext;
  logic [DSIZE:0] res;

  // The two top bits of the widened result differ only on overflow; the top bit gives the direction.
  always_comb begin
    a_ext = {a[DSIZE-1], a};
    b_ext = {b[DSIZE-1], b};
    res   = sub ? (a_ext - b_ext) : (a_ext + b_ext);
    if (res[DSIZE] == res[DSIZE-1]) begin
      y = res[DSIZE-1:0];
    end else if (res[DSIZE]) begin
      y = SAT_MIN;
    end else begin
      y = SAT_MAX;
    end
  end

endmodule

// File: rtl/lif_spike_generator.sv
// Leaky integrate-and-fire neuron: integrates weight beats, leaks, compares, and emits a spike.
// Define NEURON_REFRACTORY_EN to suppress integration for REFRAC_CYCLES steps after each spike.
module lif_spike_generator
  import lif_spike_generator_pkg::*;
#(
  parameter int DSIZE      = 16,
  parameter int LEAK_SHIFT = 4
`ifdef NEURON_REFRACTORY_EN
  ,
  parameter int REFRAC_CYCLES = 3
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_valid,
  output logic             w_ready,
  input  logic [DSIZE-1:0] w_data,
  input  logic             w_last,
  input  logic [DSIZE-1:0] threshold,
  input  logic [DSIZE-1:0] v_reset,
  output logic             spike_valid,
  input  logic             spike_ready,
  output logic [DSIZE-1:0] potential,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [DSIZE-1:0] pot_q, pot_d;
  logic [DSIZE-1:0] int_sum;
  logic [DSIZE-1:0] leak_amt;
  logic [DSIZE-1:0] leak_res;
  logic             pot_ge_thr;
  logic             refrac_active;

`ifdef NEURON_REFRACTORY_EN
  localparam int RC_W = (REFRAC_CYCLES > 0) ? $clog2(REFRAC_CYCLES + 1) : 1;
  logic [RC_W-1:0] refrac_q, refrac_d;
  assign refrac_active = (refrac_q != '0);
`else
  assign refrac_active = 1'b0;
`endif

  assign leak_amt   = $unsigned($signed(pot_q) >>> LEAK_SHIFT);
  assign pot_ge_thr = ($signed(pot_q) >= $signed(threshold));
  assign potential  = pot_q;
  assign busy       = (state_q != ST_INTEG);

  sat_add_sub #(.DSIZE(DSIZE)) u_integ (
    .a   (pot_q),
    .b   (w_data),
    .sub (1'b0),
    .y   (int_sum)
  );

  sat_add_sub #(.DSIZE(DSIZE)) u_leak (
    .a   (pot_q),
    .b   (leak_amt),
    .sub (1'b1),
    .y   (leak_res)
  );

  always_comb begin
    state_d     = state_q;
    pot_d       = pot_q;
    w_ready     = 1'b0;
    spike_valid = 1'b0;
`ifdef NEURON_REFRACTORY_EN
    refrac_d    = refrac_q;
`endif
    unique case (state_q)
      ST_INTEG: begin
        w_ready = 1'b1;
        if (w_valid) begin
          // While refractory, beats are consumed but the potential stays at v_reset.
          if (refrac_active) begin
`ifdef NEURON_REFRACTORY_EN
            if (w_last) begin
              refrac_d = refrac_q - RC_W'(1);
            end
`endif
          end else begin
            pot_d = int_sum;
            if (w_last) begin
              state_d = ST_LEAK;
            end
          end
        end
      end
      ST_LEAK: begin
        pot_d   = leak_res;
        state_d = ST_CMP;
      end
      ST_CMP: begin
        state_d = pot_ge_thr ? ST_FIRE : ST_INTEG;
      end
      ST_FIRE: begin
        spike_valid = 1'b1;
        if (spike_ready) begin
          pot_d   = v_reset;
          state_d = ST_INTEG;
`ifdef NEURON_REFRACTORY_EN
          refrac_d = RC_W'(REFRAC_CYCLES);
`endif
        end
      end
      default: begin
        state_d = ST_INTEG;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_INTEG;
      pot_q    <= '0;
`ifdef NEURON_REFRACTORY_EN
      refrac_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pot_q    <= pot_d;
`ifdef NEURON_REFRACTORY_EN
      refrac_q <= refrac_d;
`endif
    end
  end

endmodule
